// File: rtl/block_mem_requester_pkg.sv
// Shared state encoding and block-address helpers for the block-memory requester.
// The bump address is what makes every request look like a fresh access to the memory.
package mem_if_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUMP,
        WAIT,
        DONE
    } state_e;

    localparam int unsigned TIMER_WIDTH = 8;

    function automatic int unsigned block_size(input int unsigned offsetWidth);
        return 32'd1 << offsetWidth;
    endfunction

    function automatic logic [31:0] align_addr(input logic [31:0] addr, input int unsigned offsetWidth);
        return addr & ~((32'd1 << offsetWidth) - 32'd1);
    endfunction

    // Flipping only the block-index LSB moves to a neighbouring block, so even the top block cannot overflow.
    function automatic logic [31:0] bump_addr(input logic [31:0] addr, input int unsigned offsetWidth);
        return align_addr(addr, offsetWidth) ^ (32'd1 << offsetWidth);
    endfunction

endpackage

// File: rtl/block_mem_requester_if.sv
// Cache-side request/response bundle and memory-side block bus used by the requester.
// On block_req_if the cache is the master; on block_mem_if the requester is the master.
interface block_req_if
    import mem_if_pkg::*;
#(
    parameter int unsigned DATA_WIDTH         = 32,
    parameter int unsigned ADDR_WIDTH         = 10,
    parameter int unsigned BLOCK_OFFSET_WIDTH = 3
) ();
    localparam int unsigned BLOCK_BITS = block_size(BLOCK_OFFSET_WIDTH) * DATA_WIDTH;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [BLOCK_BITS-1:0] req_wdata;
    logic                  resp_valid;
    logic                  resp_err;
    logic [BLOCK_BITS-1:0] resp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_err, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, resp_valid, resp_err, resp_rdata
    );
endinterface

interface block_mem_if
    import mem_if_pkg::*;
#(
    parameter int unsigned DATA_WIDTH         = 32,
    parameter int unsigned ADDR_WIDTH         = 10,
    parameter int unsigned BLOCK_OFFSET_WIDTH = 3
) ();
    localparam int unsigned BLOCK_BITS = block_size(BLOCK_OFFSET_WIDTH) * DATA_WIDTH;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [BLOCK_BITS-1:0] mem_block_din;
    logic                  mem_we;
    logic                  mem_block_valid;
    logic [BLOCK_BITS-1:0] mem_block_dout;

    modport master (
        output mem_addr, mem_block_din, mem_we,
        input  mem_block_valid, mem_block_dout
    );

    modport slave (
        input  mem_addr, mem_block_din, mem_we,
        output mem_block_valid, mem_block_dout
    );
endinterface

// File: rtl/block_mem_requester.sv
// Initiator for the address-stable block memory: one block read/write per request, with an
// address bump before each access and a timeout if the memory never reports block_valid.
module block_mem_requester
    import mem_if_pkg::*;
#(
    parameter int unsigned DATA_WIDTH         = 32,
    parameter int unsigned ADDR_WIDTH         = 10,
    parameter int unsigned BLOCK_OFFSET_WIDTH = 3,
    parameter int unsigned TIMEOUT_CYCLES     = 255
) (
    input  logic        clk,
    input  logic        rstn,
    block_req_if.slave  req,
    block_mem_if.master mem
);
    localparam int unsigned BLOCK_SIZE = block_size(BLOCK_OFFSET_WIDTH);
    localparam int unsigned BLOCK_BITS = BLOCK_SIZE * DATA_WIDTH;
    localparam logic [TIMER_WIDTH-1:0] TIMER_INIT = TIMER_WIDTH'(TIMEOUT_CYCLES);

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  reqAddr_q, reqAddr_d;
    logic                   reqWe_q, reqWe_d;
    logic [BLOCK_BITS-1:0]  reqWdata_q, reqWdata_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic                   respErr_q, respErr_d;
    logic [BLOCK_BITS-1:0]  respRdata_q, respRdata_d;
    logic [ADDR_WIDTH-1:0]  memAddr_q, memAddr_d;
    logic [BLOCK_BITS-1:0]  memDin_q, memDin_d;
    logic                   memWe_q, memWe_d;

    logic                   firstWait;
    logic [ADDR_WIDTH-1:0]  alignedReqAddr;
    logic [ADDR_WIDTH-1:0]  bumpedReqAddr;

    assign alignedReqAddr = ADDR_WIDTH'(align_addr(32'(req.req_addr), BLOCK_OFFSET_WIDTH));
    assign bumpedReqAddr  = ADDR_WIDTH'(bump_addr(32'(req.req_addr), BLOCK_OFFSET_WIDTH));

    // The timer only leaves its reload value inside WAIT, so a full timer marks the first WAIT cycle,
    // where a block_valid left over from the previous access must not complete this one.
    assign firstWait = (timer_q == TIMER_INIT);

    always_comb begin
        state_d     = state_q;
        reqAddr_d   = reqAddr_q;
        reqWe_d     = reqWe_q;
        reqWdata_d  = reqWdata_q;
        timer_d     = timer_q;
        respErr_d   = respErr_q;
        respRdata_d = respRdata_q;
        memAddr_d   = memAddr_q;
        memDin_d    = memDin_q;
        memWe_d     = memWe_q;

        unique case (state_q)
            IDLE: begin
                memWe_d = 1'b0;
                if (req.req_valid) begin
                    reqAddr_d  = alignedReqAddr;
                    reqWe_d    = req.req_we;
                    reqWdata_d = req.req_wdata;
                    memAddr_d  = bumpedReqAddr;
                    state_d    = BUMP;
                end
            end
            BUMP: begin
                memAddr_d = reqAddr_q;
                memWe_d   = reqWe_q;
                memDin_d  = reqWdata_q;
                state_d   = WAIT;
            end
            WAIT: begin
                timer_d = timer_q - 1'b1;
                if (mem.mem_block_valid && !firstWait) begin
                    if (!reqWe_q) begin
                        respRdata_d = mem.mem_block_dout;
                    end
                    respErr_d = 1'b0;
                    state_d   = DONE;
                end else if (timer_q == TIMER_WIDTH'(1)) begin
                    respErr_d = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                memWe_d = 1'b0;
                timer_d = TIMER_INIT;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            reqAddr_q   <= '0;
            reqWe_q     <= 1'b0;
            reqWdata_q  <= '0;
            timer_q     <= TIMER_INIT;
            respErr_q   <= 1'b0;
            respRdata_q <= '0;
            memAddr_q   <= '0;
            memDin_q    <= '0;
            memWe_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            reqAddr_q   <= reqAddr_d;
            reqWe_q     <= reqWe_d;
            reqWdata_q  <= reqWdata_d;
            timer_q     <= timer_d;
            respErr_q   <= respErr_d;
            respRdata_q <= respRdata_d;
            memAddr_q   <= memAddr_d;
            memDin_q    <= memDin_d;
            memWe_q     <= memWe_d;
        end
    end

    assign req.req_ready  = (state_q == IDLE);
    assign req.resp_valid = (state_q == DONE);
    assign req.resp_err   = respErr_q;
    assign req.resp_rdata = respRdata_q;

    assign mem.mem_addr      = memAddr_q;
    assign mem.mem_block_din = memDin_q;
    assign mem.mem_we        = memWe_q;

endmodule
